// File: rtl/fifo_burst_drain.sv
// ---------------------------------------------------------------------------
// fifo_burst_drain
//
// Purpose:
//   Read-side consumer for the synchronous FIFO. It pops words through
//   fifo_rd_en and absorbs the FIFO's one-cycle registered read latency in a
//   two-entry output buffer. The words are presented on a valid/ready stream
//   that is framed into fixed bursts of BURST_LEN beats, and m_last marks the
//   final beat of each burst. The drain starts and stops on burst boundaries
//   under control of en.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           drain enable, sampled every cycle
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO read data, valid the cycle after a pop
//   fifo_rd_en   FIFO pop request (combinational, depends on m_ready)
//   m_valid      output word valid
//   m_ready      downstream ready
//   m_data       output word (driven from a register)
//   m_last       last beat of a burst
//   busy         state machine is not idle
//   burst_count  completed bursts (only when DRAIN_STATS_EN is defined)
//
// Configuration:
//   DRAIN_STATS_EN  when defined, burst_count is a saturating counter of
//                   completed bursts. When undefined, burst_count is tied to 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_burst_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  burst_count
);

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  read_allowed;

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_next;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  infl;
  logic                  pop;
  logic                  wr_tail;
  logic [2:0]            pending;

  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      beat_idx;

  // Stream side. The head entry drives the outputs directly, so there is no
  // combinational path from fifo_dout to m_data.
  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid & (beat_idx == LAST_IDX);
  assign pop     = m_valid & m_ready;
  assign busy    = (state != IDLE);

  // Read issue. pending counts the words the buffer must still hold after
  // this cycle: buffered words plus the in-flight word, minus the word popped
  // now. Counting the pop lets the block sustain one word per cycle, and it
  // is the reason fifo_rd_en depends combinationally on m_ready.
  assign pending    = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  assign fifo_rd_en = read_allowed & ~fifo_empty & (pending < 3'd2);

  // State register. Reset returns to IDLE, which stops reads immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and read permission. In STOP, reads continue only while
  // rd_idx is mid-burst, so every burst that is started also finishes. The
  // block returns to IDLE only after the last word of that burst has been
  // delivered downstream.
  always_comb begin
    state_next   = state;
    read_allowed = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        read_allowed = 1'b1;
        if (!en) begin
          state_next = STOP;
        end
      end
      STOP: begin
        read_allowed = (rd_idx != '0);
        if (en) begin
          state_next = RUN;
        end else if ((rd_idx == '0) && !infl && (occ == 2'd0)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The in-flight flag follows fifo_rd_en by one cycle. Because reset clears
  // it, a word still in flight from the FIFO when reset hits is never
  // captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl <= 1'b0;
    end else begin
      infl <= fifo_rd_en;
    end
  end

  // Next contents of the two-entry buffer. A pop shifts the tail into the
  // head. A returning word is then written to the first free slot after that
  // shift. When occ is 2 with both a pop and a capture, the data shifts and
  // refills, and occ stays at 2. The read rule prevents a capture into a full
  // buffer that has no pop.
  always_comb begin
    head_next = head_q;
    tail_next = tail_q;
    wr_tail   = (occ == 2'd2) || ((occ == 2'd1) && !pop);
    if (pop) begin
      head_next = tail_q;
    end
    if (infl) begin
      if (wr_tail) begin
        tail_next = fifo_dout;
      end else begin
        head_next = fifo_dout;
      end
    end
    occ_next = occ + {1'b0, infl} - {1'b0, pop};
  end

  // Buffer registers. Reset empties the buffer and clears the data, so
  // m_data reads 0 while the block is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ    <= 2'd0;
    end else begin
      head_q <= head_next;
      tail_q <= tail_next;
      occ    <= occ_next;
    end
  end

  // Burst framing counters. rd_idx tracks issued reads and beat_idx tracks
  // delivered beats, both modulo BURST_LEN. STOP uses rd_idx to finish the
  // current burst on the read side. beat_idx places m_last, so bubbles and
  // stalls have no effect on framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx   <= '0;
      beat_idx <= '0;
    end else begin
      if (fifo_rd_en) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
      if (pop) begin
        beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
      end
    end
  end

`ifdef DRAIN_STATS_EN
  logic [CNT_WIDTH-1:0] burst_cnt_q;

  // Completed-burst counter. It advances on each delivered m_last beat and
  // holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
    end else if (pop && m_last && !(&burst_cnt_q)) begin
      burst_cnt_q <= burst_cnt_q + 1'b1;
    end
  end

  assign burst_count = burst_cnt_q;
`else
  assign burst_count = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_drain
//
// Purpose:
//   Self-checking bench for fifo_burst_drain. A queue-based FIFO model feeds
//   the DUT and returns registered read data. Each word written to the model
//   is also pushed onto an expected-data scoreboard. Each accepted output beat
//   pops the scoreboard and is compared, together with the expected m_last
//   position from a beat counter kept by the bench.
//
// Configuration:
//   DRAIN_STATS_EN  selects the expected burst_count behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_burst_drain;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] burst_count;

  fifo_burst_drain #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .burst_count (burst_count)
  );

  // Clock generation: 10 ns period with the first rising edge at 5 ns
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model contents and output scoreboard
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int outstanding = 0;
  int beat        = 0;
  int exp_bursts  = 0;
  int pop_count   = 0;
  int rd_count    = 0;
  int last_count  = 0;
  int first_rd    = -1;
  int first_valid = -1;
  int first_pop   = -1;
  int last_pop    = -1;
  logic          stalled_prev = 1'b0;
  logic [DW-1:0] prev_data    = '0;
  logic          prev_last    = 1'b0;

  // Single comparison point: counts the comparison and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Write one word into the FIFO model and record it as expected output
  task automatic applyStimulus(input logic [DW-1:0] value);
    fifo_q.push_back(value);
    exp_q.push_back(value);
    fifo_empty = 1'b0;
  endtask

  function automatic int expected_burst_count();
`ifdef DRAIN_STATS_EN
    return exp_bursts;
`else
    return 0;
`endif
  endfunction

  // One clock cycle. Called at a falling edge once inputs are set. Samples
  // the DUT just before the rising edge, scores the cycle, then updates the
  // FIFO model just after the edge.
  task automatic run_cycle();
    logic rd;
    logic pp;
    #4;
    rd = fifo_rd_en;
    pp = m_valid & m_ready;
    if (rd) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    checkOutput("rd_while_empty", 32'(rd & fifo_empty), 32'd0);
    checkOutput("rd_over_limit", 32'(rd && ((outstanding - int'(pp)) >= 2)), 32'd0);
    if (stalled_prev) begin
      checkOutput("stall_valid", 32'(m_valid), 32'd1);
      checkOutput("stall_data", 32'(m_data), 32'(prev_data));
      checkOutput("stall_last", 32'(m_last), 32'(prev_last));
    end
    if (pp) begin
      checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) checkOutput("data", 32'(m_data), 32'(exp_q.pop_front()));
      checkOutput("last", 32'(m_last), 32'(beat == BL - 1));
      if (m_last) last_count++;
      if (beat == BL - 1) exp_bursts++;
      beat = (beat + 1) % BL;
      pop_count++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    outstanding  = outstanding + int'(rd) - int'(pp);
    stalled_prev = m_valid & ~m_ready;
    prev_data    = m_data;
    prev_last    = m_last;
    cyc++;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  // Run until the scoreboard empties, or until a cycle budget runs out
  task automatic run_until_drained(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      run_cycle();
    end
    checkOutput("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Assert reset at a falling edge and clear every model. fifo_dout is left
  // unchanged, so a stale in-flight word stays on the bus.
  task automatic do_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty   = 1'b1;
    outstanding  = 0;
    beat         = 0;
    exp_bursts   = 0;
    pop_count    = 0;
    rd_count     = 0;
    last_count   = 0;
    first_rd     = -1;
    first_valid  = -1;
    first_pop    = -1;
    last_pop     = -1;
    stalled_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    @(negedge clk);

    // Reset state
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_last", 32'(m_last), 32'd0);
    checkOutput("rst_data", 32'(m_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("rst_burst_count", 32'(burst_count), 32'd0);

    // Test 1: full-rate drain of 0..15
    do_reset();
    for (int i = 0; i < 16; i++) applyStimulus(DW'(i));
    en = 1'b1;
    m_ready = 1'b1;
    run_until_drained(60);
    repeat (3) run_cycle();
    checkOutput("t1_pops", 32'(pop_count), 32'd16);
    checkOutput("t1_rd_pulses", 32'(rd_count), 32'd16);
    checkOutput("t1_lasts", 32'(last_count), 32'd4);
    checkOutput("t1_latency", 32'(first_valid - first_rd), 32'd2);
    checkOutput("t1_consecutive", 32'(last_pop - first_pop), 32'd15);
    checkOutput("t1_burst_count", 32'(burst_count), 32'(expected_burst_count()));

    // Test 2: m_ready toggles every cycle
    do_reset();
    for (int i = 0; i < 16; i++) applyStimulus(DW'(8'h20 + i));
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      m_ready = (i % 2 == 0);
      run_cycle();
    end
    checkOutput("t2_drain_done", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_pops", 32'(pop_count), 32'd16);
    m_ready = 1'b1;

    // Test 3: en dropped on the sixth pop, so the drain stops after 8 words
    do_reset();
    for (int i = 0; i < 16; i++) applyStimulus(DW'(8'h40 + i));
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (en && pop_count == 5 && m_valid) en = 1'b0;
      run_cycle();
    end
    checkOutput("t3_pops", 32'(pop_count), 32'd8);
    checkOutput("t3_lasts", 32'(last_count), 32'd2);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    checkOutput("t3_fifo_left", 32'(fifo_q.size()), 32'd8);
    checkOutput("t3_idle_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("t3_idle_valid", 32'(m_valid), 32'd0);

    // Test 4: FIFO runs empty mid-burst
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    applyStimulus(8'h61);
    applyStimulus(8'h62);
    repeat (8) run_cycle();
    checkOutput("t4a_pops", 32'(pop_count), 32'd2);
    checkOutput("t4a_lasts", 32'(last_count), 32'd0);
    checkOutput("t4a_bubble", 32'(m_valid), 32'd0);
    checkOutput("t4a_busy", 32'(busy), 32'd1);
    applyStimulus(8'h63);
    applyStimulus(8'h64);
    repeat (8) run_cycle();
    checkOutput("t4b_pops", 32'(pop_count), 32'd4);
    checkOutput("t4b_lasts", 32'(last_count), 32'd1);

    // Test 5: asynchronous reset with a full buffer, then a clean burst
    do_reset();
    en = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(DW'(8'h70 + i));
    repeat (5) run_cycle();
    checkOutput("t5_full_valid", 32'(m_valid), 32'd1);
    checkOutput("t5_full_rd_en", 32'(fifo_rd_en), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", 32'(m_valid), 32'd0);
    checkOutput("t5_async_data", 32'(m_data), 32'd0);
    checkOutput("t5_async_busy", 32'(busy), 32'd0);
    checkOutput("t5_async_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(DW'(8'h80 + i));
    repeat (3) run_cycle();
    // reset while data is still streaming, likely with a word in flight
    do_reset();
    for (int i = 0; i < 8; i++) applyStimulus(DW'(8'hC0 + i));
    run_until_drained(40);
    repeat (2) run_cycle();
    checkOutput("t5_pops", 32'(pop_count), 32'd8);
    checkOutput("t5_lasts", 32'(last_count), 32'd2);
    checkOutput("t5_burst_count", 32'(burst_count), 32'(expected_burst_count()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time limit, so the run always ends with a summary line
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Downstream consumer of the synchronous FIFO (wr_en/rd_en/din/dout/full/empty interface).
- Pops words from the FIFO read side, absorbs the FIFO's 1-cycle registered read latency, and presents them on a valid/ready stream.
- Frames the stream into fixed bursts of BURST_LEN words, with m_last on the final beat of each burst.
- Supports burst-aligned start/stop via en.

Parameters:
- DATA_WIDTH, 8: word width; must match the FIFO DATA_WIDTH.
- BURST_LEN, 4: words per burst; legal range 2..256.
- CNT_WIDTH, 16: width of the optional burst statistics counter.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  drain enable; sampled every cycle.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_WIDTH  FIFO read data; valid the cycle after a rd_en to a non-empty FIFO.
- fifo_rd_en  output  1  FIFO pop request.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  output word.
- m_last  output  1  last beat of a burst.
- busy  output  1  high when state is not IDLE.
- burst_count  output  CNT_WIDTH  completed bursts (only with DRAIN_STATS_EN).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: all outputs 0, state IDLE, all counters 0, buffer empty.
  - Reset mid-burst discards buffered and in-flight data.
  - An in-flight FIFO word returning after reset is ignored.
- Output buffer: 2 entries, in order. m_data/m_valid are driven from the head entry (registered, no combinational path from fifo_dout).
- Occupancy terms:
  - occ = buffered words, 0..2.
  - infl = 1 if fifo_rd_en was asserted the previous cycle, else 0.
  - pop = m_valid & m_ready.
  - On each cycle with infl=1, fifo_dout is captured into the buffer.
- Read issue: fifo_rd_en = read_allowed & !fifo_empty & ((occ + infl - pop) < 2).
  - fifo_rd_en is combinational from m_ready.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Counters:
  - rd_idx counts issued reads modulo BURST_LEN.
  - beat_idx counts popped beats modulo BURST_LEN.
  - m_last = m_valid & (beat_idx == BURST_LEN-1).
- State machine:
  - IDLE: read_allowed=0. en=1 -> RUN.
  - RUN: read_allowed=1. en=0 -> STOP.
  - STOP: read_allowed = (rd_idx != 0), so reads continue only to complete the current burst.
    - en=1 -> RUN.
    - rd_idx==0 & infl==0 & occ==0 (and no capture pending) -> IDLE.
- Guarantee: every stop is burst-aligned. No partial burst is left in the block or the FIFO.
- Throughput: 1 word/cycle sustained when the FIFO is non-empty and m_ready=1. First m_valid appears 2 cycles after the first fifo_rd_en edge.
- Backpressure: m_valid=1 with m_ready=0 holds m_data/m_last stable. Reads stop once occ+infl reaches 2.
- FIFO goes empty mid-burst: m_valid drops (bubble), the burst resumes when data arrives, and m_last position is unaffected.
- Simultaneous capture and pop with occ=2: legal, occ stays 2.
- en toggled 1->0->1 within a burst: no effect on framing.

Optional Feature:
- Macro: DRAIN_STATS_EN.
- Defined: burst_count increments on each pop with m_last=1, saturates at all-ones, and resets to 0.
- Undefined: burst_count is driven constant 0 and no counter logic is synthesized.

Test Plan:
1. Reset, en=1, FIFO preloaded with 0..15, m_ready=1 -> m_data 0..15 on 16 consecutive cycles; m_last on values 3, 7, 11, 15; 16 rd_en pulses total.
2. 16 words loaded, m_ready toggled 1/0 each cycle -> all 16 words in order, no loss or duplication; m_data stable while stalled; fifo_rd_en never asserted with occ+infl-pop>=2.
3. en dropped after 6 words popped, 16 loaded -> exactly 8 words output (m_last on 8th word); busy falls; FIFO retains 8 words; fifo_rd_en=0 in IDLE.
4. Only 2 words written, en=1 -> 2 beats, no m_last; writing 2 more words -> beats 3 and 4, m_last on the 4th; fifo_rd_en never high while empty.
5. rst_n pulsed low mid-burst with occ=2 -> outputs 0 immediately (asynchronous); after release, the next burst's m_last falls on its 4th beat.
6. With DRAIN_STATS_EN defined, 16 words drained -> burst_count=4. Without it -> burst_count=0 throughout.
